// File: rtl/sseg_scan_n_if.sv
// Bundle of the scanner's display inputs and pin outputs.
// master drives the digit data; slave is the scanner that drives the pins.
interface sseg_scan_n_if #(
  parameter int DIGITS      = 3,
  parameter int BRIGHT_BITS = 4
);
  logic [4*DIGITS-1:0]    hex;
  logic [DIGITS-1:0]      dp;
  logic [DIGITS-1:0]      blank;
  logic [DIGITS-1:0]      blink;
  logic                   lz_blank;
  logic [BRIGHT_BITS-1:0] brightness;
  logic [7:0]             ss;
  logic [DIGITS-1:0]      en;

  modport master (
    output hex, dp, blank, blink, lz_blank, brightness,
    input  ss, en
  );

  modport slave (
    input  hex, dp, blank, blink, lz_blank, brightness,
    output ss, en
  );
endinterface

// File: rtl/sseg_scan_n.sv
// Multiplexed N-digit seven-segment scanner with hex decode, blanking, blink,
// leading-zero suppression, PWM dimming and a dark gap between digits.
module sseg_scan_n #(
  parameter int DIGITS         = 3,
  parameter int PRESCALE_BITS  = 16,
  parameter int BRIGHT_BITS    = 4,
  parameter int BLINK_BITS     = 24,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit EN_ACTIVE_LOW  = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  sseg_scan_n_if.slave bus
);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [7:0]        SS_OFF = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0] EN_OFF = EN_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  logic [PRESCALE_BITS-1:0] prescale_q, prescale_d;
  logic [BLINK_BITS-1:0]    blink_q, blink_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [7:0]               ss_q, ss_d;
  logic [DIGITS-1:0]        en_q, en_d;

  logic                     wrap;
  logic [3:0]               nib;
  logic                     dp_sel, blank_sel, blink_sel, upper_nz;
  logic [DIGITS-1:0]        en_sel;
  logic                     lz_sup, pwm_off, dark;
  logic [6:0]               seg;

  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'h0: decode = 7'h3F;
      4'h1: decode = 7'h06;
      4'h2: decode = 7'h5B;
      4'h3: decode = 7'h4F;
      4'h4: decode = 7'h66;
      4'h5: decode = 7'h6D;
      4'h6: decode = 7'h7D;
      4'h7: decode = 7'h07;
      4'h8: decode = 7'h7F;
      4'h9: decode = 7'h6F;
      4'hA: decode = 7'h77;
      4'hB: decode = 7'h7C;
      4'hC: decode = 7'h39;
      4'hD: decode = 7'h5E;
      4'hE: decode = 7'h79;
      default: decode = 7'h71;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      prescale_q <= '0;
      blink_q    <= '0;
      idx_q      <= '0;
      ss_q       <= SS_OFF;
      en_q       <= EN_OFF;
    end else begin
      prescale_q <= prescale_d;
      blink_q    <= blink_d;
      idx_q      <= idx_d;
      ss_q       <= ss_d;
      en_q       <= en_d;
    end
  end

  // The digit index only moves on the prescaler wrap, so each digit owns a full slot.
  always_comb begin
    wrap       = &prescale_q;
    prescale_d = prescale_q + 1'b1;
    blink_d    = blink_q + 1'b1;
    idx_d      = idx_q;
    if (wrap) begin
      idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
  end

  always_comb begin
    nib       = '0;
    dp_sel    = 1'b0;
    blank_sel = 1'b0;
    blink_sel = 1'b0;
    upper_nz  = 1'b0;
    en_sel    = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        nib       = bus.hex[4*i +: 4];
        dp_sel    = bus.dp[i];
        blank_sel = bus.blank[i];
        blink_sel = bus.blink[i];
        en_sel[i] = 1'b1;
      end
      if ((IDX_W'(i) >= idx_q) && (bus.hex[4*i +: 4] != 4'h0)) upper_nz = 1'b1;
    end
  end

  // Suppressed leading zeros keep the enable and dp; only a..g go dark.
  always_comb begin
    lz_sup  = bus.lz_blank && (idx_q != '0) && !upper_nz;
    pwm_off = prescale_q[PRESCALE_BITS-1 -: BRIGHT_BITS] > bus.brightness;
    dark    = wrap || blank_sel || (blink_sel && blink_q[BLINK_BITS-1]) || pwm_off;
    seg     = lz_sup ? 7'h00 : decode(nib);
    ss_d    = SS_OFF;
    en_d    = EN_OFF;
    if (!dark) begin
      ss_d = {dp_sel, seg} ^ SS_OFF;
      en_d = en_sel ^ EN_OFF;
    end
  end

  assign bus.ss = ss_q;
  assign bus.en = en_q;
endmodule

// File: tb/tb_sseg_scan_n.sv
// Scoreboard bench for sseg_scan_n: a timeline model predicts the pins from
// cycles elapsed since reset; a monitor compares every cycle's pin values.
module tb_sseg_scan_n;
  localparam int DIGITS = 3;
  localparam int PB     = 4;
  localparam int BB     = 2;
  localparam int KB     = 6;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   t = 0;

  logic [10:0] exp_q[$];
  logic [6:0]  seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  sseg_scan_n_if #(.DIGITS(DIGITS), .BRIGHT_BITS(BB)) bus();

  sseg_scan_n #(
    .DIGITS(DIGITS), .PRESCALE_BITS(PB), .BRIGHT_BITS(BB), .BLINK_BITS(KB),
    .SEG_ACTIVE_LOW(1'b1), .EN_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  // Expected {en, ss} at the pins one cycle after an edge taken t cycles after reset.
  function automatic logic [10:0] model(input int tt);
    int         slot, pre, idx;
    logic [6:0] seg;
    logic       off;
    slot = 1 << PB;
    pre  = tt % slot;
    idx  = (tt / slot) % DIGITS;
    off  = (pre == slot - 1)
        || bus.blank[idx]
        || (bus.blink[idx] && ((tt % (1 << KB)) >= (1 << (KB - 1))))
        || ((pre / (1 << (PB - BB))) > int'(bus.brightness));
    if (off) return {3'b111, 8'hFF};
    seg = seg_tab[(bus.hex >> (4 * idx)) & 12'hF];
    if (bus.lz_blank && idx >= 1 && ((bus.hex >> (4 * idx)) == 0)) seg = 7'h00;
    return {~(3'b001 << idx), ~{bus.dp[idx], seg}};
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      exp_q.push_back({3'b111, 8'hFF});
      t <= 0;
    end else begin
      exp_q.push_back(model(t));
      t <= t + 1;
    end
  end

  always @(posedge clk) begin
    logic [10:0] e;
    #1;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_underflow: got none, required one entry");
    end else begin
      e = exp_q.pop_front();
      if ({bus.en, bus.ss} !== e) begin
        n_fail++;
        $display("FAIL pins @%0t: en=%b ss=%h, required en=%b ss=%h",
                 $time, bus.en, bus.ss, e[10:8], e[7:0]);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_in(input logic [11:0] h, input logic [2:0] d, input logic [2:0] bl,
                        input logic [2:0] bk, input logic lz, input logic [1:0] br);
    bus.hex = h; bus.dp = d; bus.blank = bl; bus.blink = bk;
    bus.lz_blank = lz; bus.brightness = br;
  endtask

  initial begin
    int cnt;
    int guard;
    logic [11:0] mask;
    set_in(12'h8A0, 3'b000, 3'b000, 3'b000, 1'b0, 2'd3);
    reset = 1'b0;
    step(3);
    reset = 1'b1;
    step(150);

    set_in(12'h005, 3'b100, 3'b000, 3'b000, 1'b1, 2'd3);
    step(60);
    bus.lz_blank = 1'b0;
    step(60);

    bus.brightness = 2'd0;
    step(100);
    bus.brightness = 2'd3;
    step(100);

    bus.blink = 3'b010;
    step(200);
    bus.blank = 3'b001;
    step(100);
    bus.blank = 3'b000;

    // Land the reset a few cycles into digit 2's slot.
    guard = 0;
    while (((t / 16) % 3 != 2 || (t % 16) < 5) && guard < 100) begin
      step(1);
      guard++;
    end
    reset = 1'b0;
    step(1);
    reset = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #2;
      if (bus.en == 3'b110) cnt++;
    end
    n_checks++;
    if (cnt != 15) begin
      n_fail++;
      $display("FAIL restart_digit0_len: got %0d cycles of en=110, required 15", cnt);
    end
    step(1);

    for (int k = 0; k < 120; k++) begin
      case ($urandom_range(0, 3))
        0: mask = 12'hFFF;
        1: mask = 12'h0FF;
        2: mask = 12'h00F;
        default: mask = 12'h000;
      endcase
      set_in(12'($urandom) & mask, 3'($urandom),
             ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000,
             3'($urandom), 1'($urandom), 2'($urandom));
      if ($urandom_range(0, 19) == 0) begin
        reset = 1'b0;
        step($urandom_range(1, 2));
        reset = 1'b1;
      end
      step($urandom_range(1, 20));
    end

    step(2);
    n_checks++;
    if (exp_q.size() > 1) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, required at most 1", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sseg_scan_n.md
Name: sseg_scan_n

Overview:
- Parametrised seven-segment scanner for the board's multiplexed display.
- Replaces the fixed 3-digit decoder-plus-mux pair with one block that takes packed hex nibbles for N digits and decodes internally.
- Adds per-digit decimal point, explicit blanking, per-digit blink, leading-zero suppression, PWM brightness and an anti-ghosting dead cycle.
- Drives the board's segment and digit-enable pins directly.

Parameters:
- DIGITS, 3, number of multiplexed digits (1..8).
- PRESCALE_BITS, 16, scan prescaler width; each digit is held for 2^PRESCALE_BITS cycles (12 MHz gives about 61 Hz frame at 3 digits).
- BRIGHT_BITS, 4, brightness input width; must be <= PRESCALE_BITS.
- BLINK_BITS, 24, blink counter width; blink period is 2^BLINK_BITS cycles at 50% duty.
- SEG_ACTIVE_LOW, 1, 1 inverts ss at the pins.
- EN_ACTIVE_LOW, 1, 1 inverts en at the pins.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset (0 = reset)
- hex  in  4*DIGITS  packed nibbles; hex[3:0] is digit 0 (rightmost)
- dp  in  DIGITS  decimal point request per digit
- blank  in  DIGITS  force digit fully dark (segments, dp, enable)
- blink  in  DIGITS  digit dark during blink off-phase
- lz_blank  in  1  enable leading-zero suppression
- brightness  in  BRIGHT_BITS  0 = minimum on-time, all-ones = full on-time
- ss  out  8  segments; ss[0]=a .. ss[6]=g, ss[7]=dp
- en  out  DIGITS  digit enables, one-hot when active

Behaviour:
- One clock; every state change happens on the rising edge of clk. reset is synchronous, active-low, sampled on the rising edge of clk.
- Reset:
  - prescaler = 0, blink counter = 0, digit index = 0.
  - en = all inactive (all 1s when EN_ACTIVE_LOW).
  - ss = all off (8'hFF when SEG_ACTIVE_LOW).
  - Reset asserted mid-scan applies the same values on the next edge. The first enabled digit after release is digit 0.
- Prescaler: free-running PRESCALE_BITS counter, increments every cycle. On wrap (all-ones to 0), the digit index advances: 0, 1, ..., DIGITS-1, 0.
- Blink counter: free-running BLINK_BITS counter. The off-phase is MSB = 1.
- Outputs are registered: one cycle latency from any input, or index change, to pins.
- Dead cycle: in the cycle the prescaler equals all-ones (the cycle before the index advances), the registered en goes fully inactive and ss goes fully off. This is the anti-ghosting gap.
- Digit i is dark (en inactive, ss off) when any of the following holds:
  - blank[i] = 1;
  - blink[i] = 1 and blink MSB = 1;
  - the PWM is in its off-phase: top BRIGHT_BITS of the prescaler > brightness.
- Leading-zero suppression: applies when lz_blank = 1 and i >= 1, and every nibble from DIGITS-1 down to i is 0.
  - Segments a..g are off.
  - dp still follows dp[i].
  - en stays active.
  - Digit 0 is never suppressed.
- Decode (active-high, before inversion), a..g in bits 0..6:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
  - ss[7] = dp[i].
- Polarity inversion is applied last: ss inverted when SEG_ACTIVE_LOW, en inverted when EN_ACTIVE_LOW.
- Inputs are not latched. A mid-digit change in hex, dp, blank, blink or brightness shows one cycle later.
- DIGITS = 1: the index stays 0, and the dead cycle still occurs at each prescaler wrap.

Test Plan:
All scenarios use DIGITS=3, PRESCALE_BITS=4, BRIGHT_BITS=2, BLINK_BITS=6, active-low pins.
1. Reset and scan:
   - Stimulus: hold reset=0 for 3 cycles, then release with hex=12'h8A0, brightness=3.
   - Required: during reset, en=3'b111 and ss=8'hFF.
   - Required after release: en=110 with ss=~8'h3F (digit 0 shows "0"), then en=101 with ss=~8'h77 ("A"), then en=011 with ss=~8'h7F ("8").
   - Required: exactly one all-off cycle (en=111, ss=FF) between each digit.
2. Leading zeros:
   - Stimulus: hex=12'h005, lz_blank=1, dp=3'b100.
   - Required: digit 0 ss=~8'h6D; digit 1 ss=8'hFF with en active; digit 2 ss=~8'h80 (dp only).
   - Stimulus: set lz_blank=0.
   - Required: digit 1 shows ~8'h3F.
3. Brightness:
   - Stimulus: brightness=0.
   - Required: each digit's en is active only while prescaler[3:2]=0, i.e. 4 of 16 cycles (fewer where that window overlaps the dead cycle).
   - Stimulus: brightness=3.
   - Required: en active for 15 of 16 cycles per digit.
4. Blink and blank:
   - Stimulus: blink=3'b010.
   - Required: digit 1 dark for 32 consecutive cycles out of every 64; digits 0 and 2 unaffected.
   - Stimulus: blank=3'b001.
   - Required: digit 0 en never active.
5. Reset mid-operation:
   - Stimulus: assert reset during digit 2's slot.
   - Required: next edge gives en=111 and ss=FF.
   - Required after release: scan restarts at digit 0, with en=110 for 15 cycles.
